// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared memory and ALU.
// Latency (mem_ready high): R-type/addi/sw 4, lw 5, beq/bne/j 3 cycles; mem_ready low stalls FETCH/MEMRD/MEMWR.
module mc_control_unit #(
    parameter int Width  = 6,
    parameter bit EN_BNE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] OP,
    input  logic [Width-1:0] Funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_wr,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_dst,
    output logic             mem2reg,
    output logic             reg_wr,
    output logic [2:0]       Alucontrol,
    output logic             illegal,
    output logic             retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_X1C  = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Only the low six bits are decoded; a Width below 6 fails elaboration on these slices.
    logic [5:0] op6;
    logic [5:0] fn6;
    logic       op_ok;
    logic       fn_ok;
    logic [2:0] fn_alu;

    assign op6 = OP[5:0];
    assign fn6 = Funct[5:0];

    always_comb begin
        fn_ok  = 1'b1;
        fn_alu = ALU_ADD;
        case (fn6)
            6'b100000: fn_alu = ALU_ADD;
            6'b100010: fn_alu = ALU_SUB;
            6'b101010: fn_alu = ALU_SLT;
            6'b100100: fn_alu = ALU_AND;
            6'b100101: fn_alu = ALU_OR;
            6'b011100: fn_alu = ALU_X1C;
            default:   fn_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (op6)
            OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J: op_ok = 1'b1;
            OP_BNE:                                        op_ok = EN_BNE;
            default:                                       op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky trap flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if ((state == S_DECODE && !op_ok) || (state == S_EXECUTE && !fn_ok)) begin
            illegal <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op6)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_BNE:       state_nxt = EN_BNE ? S_BRANCH : S_TRAP;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR:  state_nxt = (op6 == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:   state_nxt = S_FETCH;
            S_MEMWR:   if (mem_ready) state_nxt = S_FETCH;
            S_EXECUTE: state_nxt = fn_ok ? S_ALUWB : S_TRAP;
            S_ALUWB:   state_nxt = S_FETCH;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            S_ADDIWB:  state_nxt = S_FETCH;
            S_BRANCH:  state_nxt = S_FETCH;
            S_JUMP:    state_nxt = S_FETCH;
            S_TRAP:    state_nxt = S_TRAP;
            default:   state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        iord       = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        reg_wr     = 1'b0;
        Alucontrol = ALU_ADD;
        retired    = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
            end
            // Branch target is precomputed here while the register file is read.
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                mem2reg = 1'b1;
                reg_wr  = 1'b1;
                retired = 1'b1;
            end
            S_MEMWR: begin
                iord    = 1'b1;
                mem_wr  = 1'b1;
                retired = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                Alucontrol = fn_alu;
            end
            S_ALUWB: begin
                reg_dst = 1'b1;
                reg_wr  = 1'b1;
                retired = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_wr  = 1'b1;
                retired = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                Alucontrol = ALU_SUB;
                pc_src     = 2'b01;
                pc_wr      = (op6 == OP_BNE) ? ~zero : zero;
                retired    = 1'b1;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_wr   = 1'b1;
                retired = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
